mac_sequencer: RTL and testbench
================================

# mac_sequencer

Controller that runs a matrix-vector product on a single `mac` instance. On `start` it latches a job descriptor, streams A-matrix row elements and B-vector elements out of two single-port read memories, and drives the MAC's `input_valid` and `accumulate_internal`. It issues one result-write strobe per output row into a result memory. It sits between the host/config registers and the MAC datapath, owning all address generation and pipeline alignment.

## Interface
Parameters:
- `ADDR_WIDTH`, 16, width of all memory addresses
- `LEN_WIDTH`, 12, width of length fields `cfg_k` and `cfg_n`

Ports:
- `clk`  in  1  clock
- `rst_in`  in  1  reset; synchronous, active-high
- `start`  in  1  job launch pulse; accepted only in IDLE
- `cfg_k`  in  LEN_WIDTH  dot-product length (elements per row)
- `cfg_n`  in  LEN_WIDTH  number of rows / outputs
- `cfg_a_base`, `cfg_b_base`, `cfg_o_base`  in  ADDR_WIDTH each  base addresses
- `stall_in`  in  1  freeze request
- `a_re`, `b_re`  out  1  memory read enables
- `a_addr`, `b_addr`  out  ADDR_WIDTH  read addresses
- `mac_valid`  out  1  drives MAC `input_valid`
- `mac_acc`  out  1  drives MAC `accumulate_internal`
- `o_we`  out  1  result write strobe, sampling MAC `out`
- `o_addr`  out  ADDR_WIDTH  result address
- `busy`  out  1  job in progress
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - `start` latches all cfg_* inputs.
  - If `cfg_k == 0` or `cfg_n == 0`, the block stays in IDLE and pulses `done` next cycle, with no reads.
  - Otherwise it goes to RUN.
- RUN, issue stage:
  - Each non-stalled cycle asserts `a_re` and `b_re`.
  - `a_addr = a_base + row*K + k` and `b_addr = b_base + k`.
  - Addresses are generated incrementally: A increments by 1; B resets to `b_base` at end of row. No multiplier.
  - k counts 0..K-1 and row counts 0..N-1.
  - After issuing (row N-1, k K-1), go to DRAIN.
- Valid stage (one cycle behind issue, matching the memories' 1-cycle read latency):
  - `mac_valid` is 1.
  - `mac_acc` = 0 when the element is k=0, else 1.
  - When the element is k=K-1, assert `o_we` with `o_addr = o_base + row` in the same cycle; MAC `out` is combinational.
- DRAIN: retires the last valid-stage element, then returns to IDLE and pulses `done`.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- `start` while busy: ignored.
- Stall:
  - `stall_in` high freezes both stages, counters and state.
  - `a_re`, `b_re`, `mac_valid` and `o_we` are held 0.
  - The memories hold read data while `re` is low; this is a requirement on the attached SRAM.
  - The pending valid-stage element fires on the first non-stalled cycle.
  - A stall in IDLE has no effect.
- Reset: all outputs are 0 and the state is IDLE on the cycle after `rst_in` is sampled high, including mid-job. A partially written result is not rolled back.

## Timing
- Reference: `start` sampled at edge 0.
- With no stall:
  - reads are issued on cycles 1..N*K;
  - `mac_valid` is high on cycles 2..N*K+1;
  - `o_we` is high on cycles 1+K, 1+2K, …, 1+N*K;
  - `done` pulses on cycle N*K+2.
- `busy` is high cycles 1..N*K+1 and low when `done` is high.
- No bubbles between rows: row r+1 element 0 follows row r element K-1 directly.
- Each stall cycle adds exactly one cycle to every later event.
- Degenerate job (K or N zero): `done` pulses on cycle 1 and `busy` never rises.
- Reset values: every output 0.

## Structure
- Package `mac_seq_pkg`: state enum `mac_seq_state_t` (IDLE, RUN, DRAIN) and typedef `mac_seq_cfg_t` for the latched descriptor.
- One sub-module is natural: `mac_seq_addr_gen`. It holds the k/row counters and incremental A/B/O address registers, with `clear`/`advance` inputs and `last_k`/`last_row` flags.
- Top level holds the FSM, the valid-stage pipeline register (valid, first, last, row address) and the stall gating.

## Test plan
- K=4, N=3, bases A=0x100, B=0x200, O=0x300 → reads A 0x100..0x10B, B 0x200..0x203 cycled; `mac_acc` pattern 0,1,1,1 ×3; `o_we` on cycles 5, 9, 13 with `o_addr` 0x300..0x302; `done` on cycle 14. Check against a MAC reference model.
- K=1, N=5 → `mac_acc` always 0; `o_we` on cycles 2..6; `done` on cycle 7.
- K=0 or N=0 → no `re`, no `o_we`; `done` on cycle 1; `busy` stays 0.
- K=3, N=2 with `stall_in` high for 2 cycles at cycle 3 → every later event shifts by 2; no element dropped or duplicated; results are unchanged.
- `a_base` = 2^16-2, K=4 → `a_addr` wraps 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- `rst_in` asserted at cycle 6 of a K=4, N=3 job → all outputs 0 at cycle 7; `start` accepted again at cycle 8 and the new job runs with nominal timing.

Source files
------------

// File: rtl/mac_seq_pkg.sv
// Shared types for the matrix-vector MAC sequencer.
package mac_seq_pkg;

   // Widths of the latched descriptor; the top-level parameters default to these.
   localparam int unsigned CfgAddrWidth = 16;
   localparam int unsigned CfgLenWidth  = 12;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain
   } mac_seq_state_t;

   // Job descriptor captured on an accepted start.
   typedef struct packed {
      logic [CfgLenWidth-1:0]  k;
      logic [CfgLenWidth-1:0]  n;
      logic [CfgAddrWidth-1:0] a_base;
      logic [CfgAddrWidth-1:0] b_base;
      logic [CfgAddrWidth-1:0] o_base;
   } mac_seq_cfg_t;

endpackage

// File: rtl/mac_seq_addr_gen.sv
// Element/row counters and incremental address generation for the MAC sequencer.
module mac_seq_addr_gen
   import mac_seq_pkg::*;
(
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    clear_i,
   input  logic                    advance_i,
   input  mac_seq_cfg_t            cfg_i,
   output logic [CfgAddrWidth-1:0] a_addr_o,
   output logic [CfgAddrWidth-1:0] b_addr_o,
   output logic [CfgAddrWidth-1:0] o_addr_o,
   output logic                    first_k_o,
   output logic                    last_k_o,
   output logic                    last_row_o
);

   localparam logic [CfgLenWidth-1:0]  LenOne  = 1;
   localparam logic [CfgAddrWidth-1:0] AddrOne = 1;

   logic [CfgLenWidth-1:0]  k_q, k_d;
   logic [CfgLenWidth-1:0]  row_q, row_d;
   // Running A offset (row*K + k) kept as a counter so no multiplier is needed.
   logic [CfgAddrWidth-1:0] a_off_q, a_off_d;

   assign first_k_o  = (k_q == '0);
   assign last_k_o   = (k_q == cfg_i.k - LenOne);
   assign last_row_o = (row_q == cfg_i.n - LenOne);

   // Addresses wrap naturally modulo 2^CfgAddrWidth.
   assign a_addr_o = cfg_i.a_base + a_off_q;
   assign b_addr_o = cfg_i.b_base + CfgAddrWidth'(k_q);
   assign o_addr_o = cfg_i.o_base + CfgAddrWidth'(row_q);

   // Next-state of the counters: clear on job launch, step on every issued element.
   always_comb begin
      k_d     = k_q;
      row_d   = row_q;
      a_off_d = a_off_q;
      if (clear_i) begin
         k_d     = '0;
         row_d   = '0;
         a_off_d = '0;
      end else if (advance_i) begin
         a_off_d = a_off_q + AddrOne;
         if (last_k_o) begin
            k_d   = '0;
            row_d = row_q + LenOne;
         end else begin
            k_d = k_q + LenOne;
         end
      end
   end

   // Counter registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         k_q     <= '0;
         row_q   <= '0;
         a_off_q <= '0;
      end else begin
         k_q     <= k_d;
         row_q   <= row_d;
         a_off_q <= a_off_d;
      end
   end

endmodule

// File: rtl/mac_sequencer.sv
// Sequencer driving one MAC through a matrix-vector product: FSM, valid stage, stall gating.
module mac_sequencer
   import mac_seq_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = CfgAddrWidth,
   parameter int unsigned LEN_WIDTH  = CfgLenWidth
) (
   input  logic                  clk,
   input  logic                  rst_in,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  cfg_k,
   input  logic [LEN_WIDTH-1:0]  cfg_n,
   input  logic [ADDR_WIDTH-1:0] cfg_a_base,
   input  logic [ADDR_WIDTH-1:0] cfg_b_base,
   input  logic [ADDR_WIDTH-1:0] cfg_o_base,
   input  logic                  stall_in,
   output logic                  a_re,
   output logic                  b_re,
   output logic [ADDR_WIDTH-1:0] a_addr,
   output logic [ADDR_WIDTH-1:0] b_addr,
   output logic                  mac_valid,
   output logic                  mac_acc,
   output logic                  o_we,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic                  busy,
   output logic                  done
);

   mac_seq_state_t state_q, state_d;
   mac_seq_cfg_t   cfg_q, cfg_d;
   logic           done_q, done_d;

   // Valid stage: the element whose read data arrives this cycle.
   logic                    vld_q, vld_d;
   logic                    first_q, first_d;
   logic                    last_q, last_d;
   logic [ADDR_WIDTH-1:0]   row_addr_q, row_addr_d;

   logic                    issue, accept;
   logic [ADDR_WIDTH-1:0]   ag_a_addr, ag_b_addr, ag_o_addr;
   logic                    ag_first_k, ag_last_k, ag_last_row;

   assign issue  = (state_q == StRun) && !stall_in;
   assign accept = (state_q == StIdle) && start;

   mac_seq_addr_gen u_addr_gen (
      .clk_i      (clk),
      .rst_i      (rst_in),
      .clear_i    (accept),
      .advance_i  (issue),
      .cfg_i      (cfg_q),
      .a_addr_o   (ag_a_addr),
      .b_addr_o   (ag_b_addr),
      .o_addr_o   (ag_o_addr),
      .first_k_o  (ag_first_k),
      .last_k_o   (ag_last_k),
      .last_row_o (ag_last_row)
   );

   // Job FSM next state: launch, run until the last element issues, drain one stage.
   always_comb begin
      state_d = state_q;
      cfg_d   = cfg_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               cfg_d = '{k: cfg_k, n: cfg_n, a_base: cfg_a_base, b_base: cfg_b_base,
                         o_base: cfg_o_base};
               // Empty jobs complete immediately without touching memory.
               if (cfg_k == '0 || cfg_n == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            if (!stall_in && ag_last_k && ag_last_row) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (!stall_in) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Valid-stage next state: follows the issue stage one cycle later, frozen by stall.
   always_comb begin
      vld_d      = vld_q;
      first_d    = first_q;
      last_d     = last_q;
      row_addr_d = row_addr_q;
      if (!stall_in) begin
         vld_d      = issue;
         first_d    = ag_first_k;
         last_d     = ag_last_k;
         row_addr_d = ag_o_addr;
      end
   end

   // State, descriptor and pipeline registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst_in) begin
         state_q    <= StIdle;
         cfg_q      <= '0;
         done_q     <= 1'b0;
         vld_q      <= 1'b0;
         first_q    <= 1'b0;
         last_q     <= 1'b0;
         row_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         cfg_q      <= cfg_d;
         done_q     <= done_d;
         vld_q      <= vld_d;
         first_q    <= first_d;
         last_q     <= last_d;
         row_addr_q <= row_addr_d;
      end
   end

   // Stall gates every strobe combinationally; addresses read as zero when idle.
   assign a_re      = issue;
   assign b_re      = issue;
   assign a_addr    = issue ? ag_a_addr : '0;
   assign b_addr    = issue ? ag_b_addr : '0;
   assign mac_valid = vld_q && !stall_in;
   assign mac_acc   = mac_valid && !first_q;
   assign o_we      = mac_valid && last_q;
   assign o_addr    = o_we ? row_addr_q : '0;
   assign busy      = (state_q != StIdle);
   assign done      = done_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer with SRAM and MAC behavioural models.
module tb_mac_sequencer;

   localparam int AW = 16;
   localparam int LW = 12;

   logic          clk = 1'b0;
   logic          rst_in, start, stall_in;
   logic [LW-1:0] cfg_k, cfg_n;
   logic [AW-1:0] cfg_a_base, cfg_b_base, cfg_o_base;
   logic          a_re, b_re, mac_valid, mac_acc, o_we, busy, done;
   logic [AW-1:0] a_addr, b_addr, o_addr;

   always #5 clk = ~clk;

   mac_sequencer #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .clk        (clk),
      .rst_in     (rst_in),
      .start      (start),
      .cfg_k      (cfg_k),
      .cfg_n      (cfg_n),
      .cfg_a_base (cfg_a_base),
      .cfg_b_base (cfg_b_base),
      .cfg_o_base (cfg_o_base),
      .stall_in   (stall_in),
      .a_re       (a_re),
      .b_re       (b_re),
      .a_addr     (a_addr),
      .b_addr     (b_addr),
      .mac_valid  (mac_valid),
      .mac_acc    (mac_acc),
      .o_we       (o_we),
      .o_addr     (o_addr),
      .busy       (busy),
      .done       (done)
   );

   // Attached SRAMs (1-cycle latency, hold data while re is low) and the MAC.
   logic [7:0]  amem [65536];
   logic [7:0]  bmem [65536];
   logic [7:0]  a_rd = 8'd0, b_rd = 8'd0;
   logic [31:0] acc = 32'd0;
   logic [31:0] mac_out;

   assign mac_out = (mac_acc ? acc : 32'd0) + {24'd0, a_rd} * {24'd0, b_rd};

   always @(posedge clk) begin
      if (a_re) a_rd <= amem[a_addr];
      if (b_re) b_rd <= bmem[b_addr];
      if (mac_valid) acc <= mac_out;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int cyc; logic [15:0] a; logic [15:0] b; } rd_t;
   typedef struct { int cyc; logic acc; } vl_t;
   typedef struct { int cyc; logic [15:0] addr; logic [31:0] data; } wr_t;

   rd_t rd_q[$];
   vl_t vl_q[$];
   wr_t wr_q[$];
   int  dn_q[$];
   rd_t rd_e;
   vl_t vl_e;
   wr_t wr_e;
   int  dn_e;

   int nchk = 0;
   int nfail = 0;
   bit mon_en = 1'b0;
   int busy_lo = 1;
   int busy_hi = 0;
   bit stall_pat [1024];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
      end
   endtask

   // Cycle (relative to start) of the c-th non-stalled cycle.
   function automatic int map_c(input int c);
      int t = 0;
      int n = 0;
      while (n < c && t < 1000) begin
         t++;
         if (!stall_pat[t]) n++;
      end
      return t;
   endfunction

   function automatic logic [31:0] row_sum(input int k, input int r, input logic [15:0] ab,
                                           input logic [15:0] bb);
      logic [31:0] s = 32'd0;
      for (int i = 0; i < k; i++) begin
         logic [15:0] aa = 16'(ab + r * k + i);
         logic [15:0] ba = 16'(bb + i);
         s = s + {24'd0, amem[aa]} * {24'd0, bmem[ba]};
      end
      return s;
   endfunction

   // Monitor: pops expected events whenever the DUT presents them.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
         chk("b_re", b_re, a_re);
         if (stall_in) chk("stall_gate", {a_re, mac_valid, o_we}, 3'b000);
         if (a_re) begin
            chk("rd_expected", rd_q.size() != 0, 1);
            if (rd_q.size() != 0) begin
               rd_e = rd_q.pop_front();
               chk("rd_cyc", cyc, rd_e.cyc);
               chk("a_addr", a_addr, rd_e.a);
               chk("b_addr", b_addr, rd_e.b);
            end
         end
         if (mac_valid) begin
            chk("vl_expected", vl_q.size() != 0, 1);
            if (vl_q.size() != 0) begin
               vl_e = vl_q.pop_front();
               chk("valid_cyc", cyc, vl_e.cyc);
               chk("mac_acc", mac_acc, vl_e.acc);
            end
         end
         if (o_we) begin
            chk("wr_expected", wr_q.size() != 0, 1);
            if (wr_q.size() != 0) begin
               wr_e = wr_q.pop_front();
               chk("o_we_cyc", cyc, wr_e.cyc);
               chk("o_addr", o_addr, wr_e.addr);
               chk("result", mac_out, wr_e.data);
            end
         end
         if (done) begin
            chk("done_expected", dn_q.size() != 0, 1);
            if (dn_q.size() != 0) begin
               dn_e = dn_q.pop_front();
               chk("done_cyc", cyc, dn_e);
            end
         end
      end
   end

   task automatic chk_outputs_zero(input string nm);
      chk(nm, {a_re, b_re, a_addr, b_addr, mac_valid, mac_acc, o_we, o_addr, busy, done},
          55'd0);
   endtask

   // Launch a job in the current cycle (called #1 after an edge); rst_at>0 resets mid-job.
   task automatic run_job(input int k, input int n, input logic [15:0] ab,
                          input logic [15:0] bb, input logic [15:0] ob, input int rst_at);
      int base, nk, last_c, lim, rt, vt, dt;
      cfg_k      = LW'(k);
      cfg_n      = LW'(n);
      cfg_a_base = ab;
      cfg_b_base = bb;
      cfg_o_base = ob;
      start      = 1'b1;
      base       = cyc;
      nk         = k * n;
      lim        = (rst_at > 0) ? rst_at : 1 << 30;
      if (nk == 0) begin
         dn_q.push_back(base + 1);
         busy_lo = 1;
         busy_hi = 0;
         last_c  = 2;
      end else begin
         busy_lo = base + 1;
         busy_hi = base + ((map_c(nk + 1) < lim) ? map_c(nk + 1) : lim);
         for (int r = 0; r < n; r++) begin
            for (int i = 0; i < k; i++) begin
               rt = map_c(r * k + i + 1);
               vt = map_c(r * k + i + 2);
               if (rt <= lim) rd_q.push_back('{base + rt, 16'(ab + r * k + i), 16'(bb + i)});
               if (vt <= lim) begin
                  vl_q.push_back('{base + vt, i != 0});
                  if (i == k - 1) wr_q.push_back('{base + vt, 16'(ob + r), row_sum(k, r, ab, bb)});
               end
            end
         end
         dt = map_c(nk + 1) + 1;
         if (dt <= lim) dn_q.push_back(base + dt);
         last_c = (rst_at > 0) ? rst_at + 1 : dt + 1;
      end
      for (int c = 1; c <= last_c; c++) begin
         @(posedge clk);
         #1;
         start    = 1'b0;
         stall_in = stall_pat[c];
         rst_in   = (c == rst_at);
         // A start while busy must be ignored, including its descriptor.
         if (nk != 0 && c == 2) begin
            start = 1'b1;
            cfg_k = LW'($urandom_range(1, 7));
            cfg_a_base = 16'($urandom);
         end
         if (rst_at > 0 && c == rst_at + 1) chk_outputs_zero("reset_mid_job");
      end
      stall_in = 1'b0;
      for (int c = 0; c < 1024; c++) stall_pat[c] = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         amem[i] = 8'($urandom);
         bmem[i] = 8'($urandom);
      end
      rst_in = 1'b1;
      start = 1'b0;
      stall_in = 1'b0;
      cfg_k = '0;
      cfg_n = '0;
      cfg_a_base = '0;
      cfg_b_base = '0;
      cfg_o_base = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_in = 1'b0;
      chk_outputs_zero("reset_state");
      mon_en = 1'b1;

      run_job(4, 3, 16'h0100, 16'h0200, 16'h0300, 0);
      run_job(1, 5, 16'h0040, 16'h0080, 16'h00C0, 0);
      run_job(0, 3, 16'h0100, 16'h0200, 16'h0300, 0);
      run_job(3, 0, 16'h0100, 16'h0200, 16'h0300, 0);
      stall_pat[3] = 1'b1;
      stall_pat[4] = 1'b1;
      run_job(3, 2, 16'h0500, 16'h0600, 16'h0700, 0);
      run_job(4, 1, 16'hFFFE, 16'h1000, 16'h2000, 0);
      run_job(4, 3, 16'h0100, 16'h0200, 16'h0300, 6);
      run_job(4, 3, 16'h0A00, 16'h0B00, 16'h0C00, 0);
      for (int j = 0; j < 8; j++) begin
         int k = $urandom_range(1, 5);
         int n = $urandom_range(1, 4);
         for (int c = 1; c <= k * n + 2; c++) stall_pat[c] = ($urandom_range(0, 3) == 0);
         run_job(k, n, 16'($urandom), 16'($urandom), 16'($urandom), 0);
      end

      repeat (3) @(posedge clk);
      #1;
      chk("rd_q_drained", rd_q.size(), 0);
      chk("vl_q_drained", vl_q.size(), 0);
      chk("wr_q_drained", wr_q.size(), 0);
      chk("dn_q_drained", dn_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
